// File: rtl/hwpe_ctrl_uloop_sched.sv
// Purpose : sequences the uloop engine for one job and queues each completed offset set as a tile descriptor.
// Latency : start_i -> first uloop_enable_o 2 cycles; uloop_valid_i -> tile_valid_o 2 cycles (queue empty).
// Backpres: a full descriptor queue drops uloop_enable_o until the consumer pops via tile_valid_o/tile_ready_i.
//
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync soft clear), start_i (job start, IDLE only)
//   uloop_enable_o / uloop_clear_o        : control towards the uloop engine
//   uloop_valid_i / uloop_done_i / uloop_accum_i / uloop_offs_i : completed offset set from the engine
//   tile_valid_o / tile_ready_i / tile_offs_o / tile_accum_o / tile_last_o : descriptor stream (FWFT head)
//   tile_cnt_o (saturating handshake count), busy_o, evt_done_o (job-end pulse)
//   perf_stall_o : only when HWPE_ULOOP_SCHED_PERF_EN is defined (stall cycle counter)
module hwpe_ctrl_uloop_sched #(
    parameter int NB_REG     = 4,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    output logic                        uloop_enable_o,
    output logic                        uloop_clear_o,
    input  logic                        uloop_valid_i,
    input  logic                        uloop_done_i,
    input  logic                        uloop_accum_i,
    input  logic [NB_REG*REG_WIDTH-1:0] uloop_offs_i,
    output logic                        tile_valid_o,
    input  logic                        tile_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0] tile_offs_o,
    output logic                        tile_accum_o,
    output logic                        tile_last_o,
    output logic [CNT_WIDTH-1:0]        tile_cnt_o,
    output logic                        busy_o,
    output logic                        evt_done_o
`ifdef HWPE_ULOOP_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_stall_o
`endif
);

    localparam int OFFS_W = NB_REG * REG_WIDTH;
    localparam int DESC_W = OFFS_W + 2;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_PUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // holding register between the engine pulse and the queue write
    logic [OFFS_W-1:0] hold_offs_q;
    logic              hold_accum_q;
    logic              hold_last_q;

    // descriptor queue storage, {last, accum, offs}
    logic [DESC_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [DESC_W-1:0] head;

    logic [CNT_WIDTH-1:0] tile_cnt_q;

    logic fifo_full, fifo_empty;
    logic push, pop;
    logic start_acc;
    logic capture;

    assign fifo_full  = (fcnt_q == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fcnt_q == '0);
    assign start_acc  = (state_q == S_IDLE) && start_i;
    // STEP only enabled the engine while not full, so a valid seen here always has room
    assign capture    = (state_q == S_STEP) && uloop_valid_i && !fifo_full;
    assign push       = (state_q == S_PUSH);
    assign pop        = tile_valid_o && tile_ready_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_CLEAR;
            S_CLEAR: state_d = S_STEP;
            S_STEP:  if (capture) state_d = S_PUSH;
            S_PUSH:  state_d = hold_last_q ? S_DRAIN : S_STEP;
            // the last descriptor was pushed before DRAIN, so empty means it was accepted
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        uloop_clear_o  = (state_q == S_CLEAR);
        // combinational on uloop_valid_i so the engine stops on the very cycle it reports
        uloop_enable_o = (state_q == S_STEP) && !fifo_full && !uloop_valid_i;
        busy_o         = (state_q != S_IDLE);
        evt_done_o     = (state_q == S_DONE);
    end

    // ---------------- holding register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_offs_q  <= '0;
            hold_accum_q <= 1'b0;
            hold_last_q  <= 1'b0;
        end else if (clear_i) begin
            hold_offs_q  <= '0;
            hold_accum_q <= 1'b0;
            hold_last_q  <= 1'b0;
        end else if (capture) begin
            hold_offs_q  <= uloop_offs_i;
            hold_accum_q <= uloop_accum_i;
            hold_last_q  <= uloop_done_i;
        end
    end

    // ---------------- descriptor queue (first-word-fall-through) ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {hold_last_q, hold_accum_q, hold_offs_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
                2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign tile_valid_o = !fifo_empty;
    assign tile_offs_o  = head[OFFS_W-1:0];
    assign tile_accum_o = head[OFFS_W];
    assign tile_last_o  = head[OFFS_W+1];

    // ---------------- accepted-descriptor counter ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tile_cnt_q <= '0;
        end else if (clear_i || start_acc) begin
            tile_cnt_q <= '0;
        end else if (pop && (tile_cnt_q != '1)) begin
            tile_cnt_q <= tile_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign tile_cnt_o = tile_cnt_q;

`ifdef HWPE_ULOOP_SCHED_PERF_EN
    // both stall sources can hit in the same cycle; each one counts
    logic [31:0] perf_q;
    logic [1:0]  perf_inc;
    logic [32:0] perf_sum;

    assign perf_inc = {1'b0, (state_q == S_STEP) && fifo_full}
                    + {1'b0, tile_valid_o && !tile_ready_i};
    assign perf_sum = {1'b0, perf_q} + {31'd0, perf_inc};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i || start_acc) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_sum[32] ? '1 : perf_sum[31:0];
        end
    end

    assign perf_stall_o = perf_q;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sched.sv
// Purpose : self-checking bench for hwpe_ctrl_uloop_sched with a random engine and consumer.
// Latency : n/a (bench).
// Backpres: consumer ready is held high, randomised or held low per test.
module tb_hwpe_ctrl_uloop_sched;

    localparam int NB_REG    = 4;
    localparam int REG_WIDTH = 32;
    localparam int DEPTH     = 2;
    localparam int CNT_WIDTH = 16;
    localparam int OW        = NB_REG * REG_WIDTH;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 start_i = 1'b0;
    logic                 uloop_enable_o, uloop_clear_o;
    logic                 uloop_valid_i = 1'b0;
    logic                 uloop_done_i = 1'b0;
    logic                 uloop_accum_i = 1'b0;
    logic [OW-1:0]        uloop_offs_i = '0;
    logic                 tile_valid_o;
    logic                 tile_ready_i = 1'b0;
    logic [OW-1:0]        tile_offs_o;
    logic                 tile_accum_o, tile_last_o;
    logic [CNT_WIDTH-1:0] tile_cnt_o;
    logic                 busy_o, evt_done_o;
`ifdef HWPE_ULOOP_SCHED_PERF_EN
    logic [31:0]          perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_uloop_sched #(
        .NB_REG    (NB_REG),
        .REG_WIDTH (REG_WIDTH),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .uloop_enable_o(uloop_enable_o),
        .uloop_clear_o (uloop_clear_o),
        .uloop_valid_i (uloop_valid_i),
        .uloop_done_i  (uloop_done_i),
        .uloop_accum_i (uloop_accum_i),
        .uloop_offs_i  (uloop_offs_i),
        .tile_valid_o  (tile_valid_o),
        .tile_ready_i  (tile_ready_i),
        .tile_offs_o   (tile_offs_o),
        .tile_accum_o  (tile_accum_o),
        .tile_last_o   (tile_last_o),
        .tile_cnt_o    (tile_cnt_o),
        .busy_o        (busy_o),
        .evt_done_o    (evt_done_o)
`ifdef HWPE_ULOOP_SCHED_PERF_EN
        ,
        .perf_stall_o  (perf_stall_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A descriptor becomes visible two cycles after the engine pulse and leaves on a handshake.
    typedef struct {
        logic [OW-1:0] offs;
        logic          accum;
        logic          last;
        int            avail;
    } desc_t;

    desc_t q[$];
    int    cyc = 0;
    bit    model_on = 0;
    bit    job_active = 0;
    int    start_cyc = 0;
    bit    last_seen = 0;
    bit    last_popped = 0;
    int    last_pop_cyc = 0;
    bit    prev_valid = 0;
    int    exp_cnt = 0;
    int    done_pulses = 0;

    initial begin
        int vis;
        bit exp_full, exp_en, exp_tv, exp_done;
        forever begin
            @(negedge clk_i);
            if (model_on) begin
                vis = 0;
                foreach (q[i]) if (q[i].avail <= cyc) vis++;
                exp_full = (vis >= DEPTH);
                exp_tv   = (vis > 0);
                exp_en   = job_active && (cyc >= start_cyc + 2) && !last_seen
                           && !uloop_valid_i && !prev_valid && !exp_full;
                exp_done = job_active && last_popped && (cyc == last_pop_cyc + 2);

                check("uloop_clear", uloop_clear_o, job_active && (cyc == start_cyc + 1));
                check("uloop_enable", uloop_enable_o, exp_en);
                check("busy", busy_o, job_active);
                check("evt_done", evt_done_o, exp_done);
                check("tile_valid", tile_valid_o, exp_tv);
                check("tile_cnt", tile_cnt_o, exp_cnt);
                if (exp_tv && tile_valid_o) begin
                    check("tile_offs", tile_offs_o, q[0].offs);
                    check("tile_accum", tile_accum_o, q[0].accum);
                    check("tile_last", tile_last_o, q[0].last);
                end
                if (evt_done_o) done_pulses++;

                if (clear_i) begin
                    q.delete();
                    job_active  = 0;
                    exp_cnt     = 0;
                    prev_valid  = 0;
                    last_seen   = 0;
                    last_popped = 0;
                end else begin
                    if (exp_tv && tile_ready_i) begin
                        if (q[0].last) begin
                            last_popped  = 1;
                            last_pop_cyc = cyc;
                        end
                        void'(q.pop_front());
                        if (exp_cnt < 65535) exp_cnt++;
                    end
                    if (job_active && uloop_valid_i && !last_seen) begin
                        q.push_back('{offs: uloop_offs_i, accum: uloop_accum_i,
                                      last: uloop_done_i, avail: cyc + 2});
                        if (uloop_done_i) last_seen = 1;
                    end
                    if (exp_done) begin
                        job_active = 0;
                    end else if (!job_active && start_i) begin
                        job_active  = 1;
                        start_cyc   = cyc;
                        exp_cnt     = 0;
                        last_seen   = 0;
                        last_popped = 0;
                    end
                    prev_valid = uloop_valid_i;
                end
            end
            cyc++;
        end
    end

    // ---------------- engine and consumer ----------------
    int            eng_nsets = 0, eng_idx = 0, eng_steps = 0, eng_need = 1;
    bit            eng_run = 0;
    int            ready_mode = 0;
    logic [OW-1:0] first_offs = '0;

    initial begin
        bit en;
        forever begin
            @(negedge clk_i);
            en = uloop_enable_o;
            @(posedge clk_i);
            #1;
            uloop_valid_i = 1'b0;
            uloop_done_i  = 1'b0;
            case (ready_mode)
                0:       tile_ready_i = 1'b1;
                1:       tile_ready_i = 1'($urandom_range(0, 1));
                default: tile_ready_i = 1'b0;
            endcase
            if (eng_run && en) begin
                eng_steps++;
                if (eng_steps >= eng_need) begin
                    uloop_valid_i = 1'b1;
                    uloop_offs_i  = {$urandom, $urandom, $urandom, $urandom};
                    uloop_accum_i = 1'($urandom_range(0, 1));
                    uloop_done_i  = (eng_idx == eng_nsets - 1);
                    if (eng_idx == 0) first_offs = uloop_offs_i;
                    eng_idx++;
                    eng_steps = 0;
                    eng_need  = $urandom_range(1, 3);
                    if (eng_idx == eng_nsets) eng_run = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int n, input int rmode);
        tick();
        ready_mode = rmode;
        eng_nsets  = n;
        eng_idx    = 0;
        eng_steps  = 0;
        eng_need   = $urandom_range(1, 3);
        eng_run    = 1;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy_o still 1 after %0d cycles", limit);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int n;
        bit seen;

        // reset state
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_tile_valid", tile_valid_o, 1'b0);
        check("rst_enable", uloop_enable_o, 1'b0);
        check("rst_uclear", uloop_clear_o, 1'b0);
        check("rst_cnt", tile_cnt_o, '0);
        check("rst_done", evt_done_o, 1'b0);
        check("rst_offs", tile_offs_o, '0);
        tick();
        rst_ni   = 1'b1;
        model_on = 1;
        repeat (2) tick();

        // 1: three tiles, consumer always ready, with start-up timing pinned
        d0 = done_pulses;
        start_job(3, 0);
        @(negedge clk_i);
        check("lit_uclear_c1", uloop_clear_o, 1'b1);
        check("lit_enable_c1", uloop_enable_o, 1'b0);
        @(negedge clk_i);
        check("lit_uclear_c2", uloop_clear_o, 1'b0);
        check("lit_enable_c2", uloop_enable_o, 1'b1);
        wait_idle(300);
        check("lit_cnt_3", tile_cnt_o, 3);
        check("lit_done_once", done_pulses - d0, 1);

        // 2: consumer stalled, queue fills, head must hold
        start_job(3, 2);
        repeat (30) @(negedge clk_i);
        check("lit_stall_valid", tile_valid_o, 1'b1);
        check("lit_stall_enable", uloop_enable_o, 1'b0);
        check("lit_stall_head", tile_offs_o, first_offs);
`ifdef HWPE_ULOOP_SCHED_PERF_EN
        check("lit_perf_ge5", perf_stall_o >= 32'd5, 1'b1);
`endif
        repeat (5) @(negedge clk_i);
        check("lit_stall_head2", tile_offs_o, first_offs);
        ready_mode = 0;
        wait_idle(300);
        check("lit_cnt_stall", tile_cnt_o, 3);

        // 3: clear mid-job with a descriptor waiting
        d0 = done_pulses;
        start_job(3, 2);
`ifdef HWPE_ULOOP_SCHED_PERF_EN
        @(negedge clk_i);
        check("lit_perf_cleared", perf_stall_o, 32'd0);
`endif
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (tile_valid_o) begin
                seen = 1;
                break;
            end
        end
        check("lit_wait_tile", seen, 1'b1);
        tick();
        clear_i = 1'b1;
        eng_run = 0;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        check("lit_clr_valid", tile_valid_o, 1'b0);
        check("lit_clr_busy", busy_o, 1'b0);
        repeat (5) @(negedge clk_i);
        check("lit_clr_nodone", done_pulses - d0, 0);
        start_job(2, 0);
        wait_idle(300);
        check("lit_cnt_after_clr", tile_cnt_o, 2);

        // 4: second start pulse during the job is ignored
        d0 = done_pulses;
        start_job(4, 1);
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_idle(400);
        check("lit_cnt_restart", tile_cnt_o, 4);
        check("lit_done_restart", done_pulses - d0, 1);

        // 5: random jobs and random backpressure
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 5);
            start_job(n, $urandom_range(0, 1));
            wait_idle(500);
            check("rand_cnt", tile_cnt_o, n);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
